// File: rtl/fl32_pkg.sv
// Shared fp32 definitions used by the fp32 datapath blocks (adder, fp32->int32 converter).
package fl32_pkg;

  localparam logic [7:0]  FL32_BIAS     = 8'd127;
  localparam logic [7:0]  FL32_EXP_MAX  = 8'hFF;
  // Exponent at which the 24-bit significand is already an integer (bias + 23).
  localparam logic [7:0]  FL32_EXP_INT  = 8'd150;
  // First exponent whose magnitude no longer fits a signed 32-bit result.
  localparam logic [7:0]  FL32_EXP_OVF  = 8'd158;
  localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN     = 32'h8000_0000;
  localparam logic [31:0] FL32_NEG_2P31 = 32'hCF00_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fl32_t;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    PACK,
    DONE
  } fl32_cvt_state_t;

endpackage

// File: rtl/fl32_to_int32_shift.sv
// Logarithmic barrel shifter; left shifts reuse the right-shift network on bit-reversed data.
module fl32_to_int32_shift #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     shift_left,
  input  logic [$clog2(WIDTH)-1:0] amount,
  output logic [WIDTH-1:0]         data_out
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] rev_in;
  logic [WIDTH-1:0] rev_out;
  logic [WIDTH-1:0] stage [SHW+1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign rev_in[gi]  = data_in[WIDTH-1-gi];
      assign rev_out[gi] = stage[SHW][WIDTH-1-gi];
    end

    for (gi = 0; gi < SHW; gi++) begin : g_stage
      assign stage[gi+1] = amount[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
    end
  endgenerate

  assign stage[0]  = shift_left ? rev_in : data_in;
  assign data_out  = shift_left ? rev_out : stage[SHW];

endmodule

// File: rtl/fl32_to_int32.sv
// fp32 -> signed int32 conversion, round toward zero, RISC-V saturation and flags.
// Multicycle IDLE/ALIGN/PACK/DONE sequencer with valid/ready on both sides.
module fl32_to_int32
  import fl32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact
);

  fl32_cvt_state_t state_reg;
  fl32_t           op_reg;

  logic [31:0] mag_reg;
  logic        neg_reg;
  logic        sat_reg;
  logic [31:0] sat_val_reg;
  logic        invalid_reg;
  logic        inexact_reg;

  logic [31:0] result_reg;
  logic        res_invalid_reg;
  logic        res_inexact_reg;

  logic [31:0] sig_ext;
  logic        shift_left;
  logic [7:0]  shift_amt_wide;
  logic [4:0]  shift_amt;
  logic [31:0] shifted;
  logic [31:0] sticky_mask;
  logic        sticky;

  logic [31:0] align_mag;
  logic        align_sat;
  logic [31:0] align_sat_val;
  logic        align_invalid;
  logic        align_inexact;
  logic [31:0] pack_result;

  assign sig_ext        = {8'd0, 1'b1, op_reg.mant};
  assign shift_left     = (op_reg.exp >= FL32_EXP_INT);
  assign shift_amt_wide = shift_left ? (op_reg.exp - FL32_EXP_INT) : (FL32_EXP_INT - op_reg.exp);
  assign shift_amt      = shift_amt_wide[4:0];

  fl32_to_int32_shift #(
    .WIDTH (32)
  ) u_shift (
    .data_in    (sig_ext),
    .shift_left (shift_left),
    .amount     (shift_amt),
    .data_out   (shifted)
  );

  // Bits that fall off the bottom of a right shift decide inexact.
  assign sticky_mask = ~(32'hFFFF_FFFF << shift_amt);
  assign sticky      = !shift_left && (|(sig_ext & sticky_mask));

  always_comb begin
    align_mag     = 32'd0;
    align_sat     = 1'b0;
    align_sat_val = INT32_MAX;
    align_invalid = 1'b0;
    align_inexact = 1'b0;
    if (op_reg.exp == FL32_EXP_MAX) begin
      align_sat     = 1'b1;
      align_invalid = 1'b1;
      align_sat_val = ((op_reg.mant != 23'd0) || !op_reg.sign) ? INT32_MAX : INT32_MIN;
    end else if (op_reg.exp >= FL32_EXP_OVF) begin
      align_sat = 1'b1;
      if (op_reg == FL32_NEG_2P31) begin
        align_sat_val = INT32_MIN;
      end else begin
        align_invalid = 1'b1;
        align_sat_val = op_reg.sign ? INT32_MIN : INT32_MAX;
      end
    end else if (op_reg.exp < FL32_BIAS) begin
      align_inexact = (op_reg.exp != 8'd0) || (op_reg.mant != 23'd0);
    end else begin
      align_mag     = shifted;
      align_inexact = sticky;
    end
  end

  assign pack_result = sat_reg ? sat_val_reg : (neg_reg ? (32'd0 - mag_reg) : mag_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      in_ready        <= 1'b1;
      out_valid       <= 1'b0;
      out_data        <= 32'd0;
      out_invalid     <= 1'b0;
      out_inexact     <= 1'b0;
      op_reg          <= '0;
      mag_reg         <= 32'd0;
      neg_reg         <= 1'b0;
      sat_reg         <= 1'b0;
      sat_val_reg     <= 32'd0;
      invalid_reg     <= 1'b0;
      inexact_reg     <= 1'b0;
      result_reg      <= 32'd0;
      res_invalid_reg <= 1'b0;
      res_inexact_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_reg    <= in_data;
            in_ready  <= 1'b0;
            state_reg <= ALIGN;
          end
        end
        ALIGN: begin
          mag_reg     <= align_mag;
          neg_reg     <= op_reg.sign;
          sat_reg     <= align_sat;
          sat_val_reg <= align_sat_val;
          invalid_reg <= align_invalid;
          inexact_reg <= align_inexact;
          state_reg   <= PACK;
        end
        PACK: begin
          result_reg      <= pack_result;
          res_invalid_reg <= invalid_reg;
          res_inexact_reg <= inexact_reg;
          state_reg       <= DONE;
        end
        DONE: begin
          // First DONE cycle presents the result; it is then held until taken.
          if (!out_valid) begin
            out_valid   <= 1'b1;
            out_data    <= result_reg;
            out_invalid <= res_invalid_reg;
            out_inexact <= res_inexact_reg;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fl32_to_int32.sv
// Bench for fl32_to_int32: directed and random operands against a real-arithmetic reference.
module tb_fl32_to_int32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fl32_to_int32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_invalid (out_invalid),
    .out_inexact (out_inexact)
  );

  // Reference: value of the float as a real, truncated toward zero, range checked.
  task automatic ref_model(input logic [31:0] x, output logic [31:0] d,
                           output logic inv, output logic inex);
    int  e;
    int  mi;
    real r;
    int  t;
    e   = int'(x[30:23]);
    mi  = int'(x[22:0]);
    inv = 1'b0;
    inex = 1'b0;
    if (e == 255) begin
      inv = 1'b1;
      d = (mi != 0 || !x[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else begin
      if (e == 0) r = real'(mi) * (2.0 ** (-149.0));
      else        r = real'(mi + 8388608) * (2.0 ** real'(e - 150));
      if (x[31]) r = -r;
      if (r >= 2147483648.0) begin
        d = 32'h7FFF_FFFF; inv = 1'b1;
      end else if (r < -2147483648.0) begin
        d = 32'h8000_0000; inv = 1'b1;
      end else begin
        t = $rtoi(r);
        d = t;
        inex = (real'(t) != r);
      end
    end
  endtask

  task automatic do_convert(input logic [31:0] x, output logic [31:0] d, output logic inv,
                            output logic inex, output int lat, output logic rdy_after);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    d    = out_data;
    inv  = out_invalid;
    inex = out_inexact;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rdy_after = in_ready && !out_valid;
    $display("conv in=%08h out=%08h inv=%0b inex=%0b lat=%0d", x, d, inv, inex, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_invalid, out_inexact} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctl got rdy/vld/inv/inex=%b required 1000",
               {in_ready, out_valid, out_invalid, out_inexact});
    end
    checks++;
    if (out_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got %08h required 00000000", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] vec [10];
    logic [31:0] req [10];
    logic [1:0]  flg [10];   // {invalid, inexact}
    logic [31:0] d, rd;
    logic        inv, inex, rinv, rinex, rdy;
    int          lat;
    vec = '{32'h40490FDB, 32'hC2F60000, 32'h4B7FFFFF, 32'h4F000000, 32'hCF000000,
            32'hCF000001, 32'h7FC00000, 32'hFF800000, 32'h3F000000, 32'h80000000};
    req = '{32'h00000003, 32'hFFFFFF85, 32'h00FFFFFF, 32'h7FFFFFFF, 32'h80000000,
            32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000};
    flg = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 10; i++) begin
      do_convert(vec[i], d, inv, inex, lat, rdy);
      ref_model(vec[i], rd, rinv, rinex);
      checks++;
      if (d !== req[i] || {inv, inex} !== flg[i]) begin
        errors++;
        $display("FAIL directed_%08h got %08h flags %b required %08h flags %b",
                 vec[i], d, {inv, inex}, req[i], flg[i]);
      end
      checks++;
      if (rd !== req[i] || {rinv, rinex} !== flg[i]) begin
        errors++;
        $display("FAIL model_%08h got %08h flags %b required %08h flags %b",
                 vec[i], rd, {rinv, rinex}, req[i], flg[i]);
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL latency_%08h got %0d required 3", vec[i], lat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, d, rd;
    logic        inv, inex, rinv, rinex, rdy;
    int          lat;
    for (int i = 0; i < 150; i++) begin
      x = $urandom;
      if ($urandom_range(3, 0) != 0) x[30:23] = 8'($urandom_range(165, 110));
      do_convert(x, d, inv, inex, lat, rdy);
      ref_model(x, rd, rinv, rinex);
      checks++;
      if (d !== rd || inv !== rinv || inex !== rinex || lat !== 3) begin
        errors++;
        $display("FAIL random_%08h got %08h inv %b inex %b lat %0d required %08h inv %b inex %b lat 3",
                 x, d, inv, inex, lat, rd, rinv, rinex);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, d, rd;
    logic        inv, inex, rinv, rinex, rdy;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      x[30:23] = 8'($urandom_range(157, 127));
      do_convert(x, d, inv, inex, lat, rdy);
      ref_model(x, rd, rinv, rinex);
      checks++;
      if (d !== rd || {inv, inex} !== {rinv, rinex}) begin
        errors++;
        $display("FAIL b2b_%08h got %08h required %08h", x, d, rd);
      end
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready got %b required 1", rdy);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic        inv, inex, rdy;
    int          lat;
    bit          seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h40490FDB;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_valid got 0 required 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h3 ||
          out_invalid !== 1'b0 || out_inexact !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold got vld %b rdy %b data %08h inv %b inex %b required 1 0 00000003 0 1",
                 out_valid, in_ready, out_data, out_invalid, out_inexact);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got vld %b rdy %b required 0 1", out_valid, in_ready);
    end
    do_convert(32'hC2F60000, d, inv, inex, lat, rdy);
    checks++;
    if (d !== 32'hFFFFFF85 || {inv, inex} !== 2'b00 || lat !== 3) begin
      errors++;
      $display("FAIL bp_next got %08h flags %b lat %0d required ffffff85 flags 00 lat 3",
               d, {inv, inex}, lat);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic        inv, inex, rdy;
    int          lat;
    bit          spurious;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h4B7FFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_flight got vld %b rdy %b data %08h required 0 1 00000000",
               out_valid, in_ready, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL rst_no_result got out_valid 1 required 0");
    end
    do_convert(32'h4B7FFFFF, d, inv, inex, lat, rdy);
    checks++;
    if (d !== 32'h00FFFFFF || {inv, inex} !== 2'b00 || lat !== 3) begin
      errors++;
      $display("FAIL rst_next got %08h flags %b lat %0d required 00ffffff flags 00 lat 3",
               d, {inv, inex}, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
